// File: rtl/nic_pkg.sv
// Shared NIC definitions: processor-port addresses, status bit position and
// the host sequencer's state and arbitration types.
package nic_pkg;

  localparam logic [1:0] ADDR_IN_BUF   = 2'b00;
  localparam logic [1:0] ADDR_IN_STAT  = 2'b01;
  localparam logic [1:0] ADDR_OUT_BUF  = 2'b10;
  localparam logic [1:0] ADDR_OUT_STAT = 2'b11;

  localparam int STAT_BIT = 63;

  typedef enum logic [2:0] {
    IDLE,
    RX_STAT,
    RX_STAT_CAP,
    RX_READ,
    RX_READ_CAP,
    TX_STAT,
    TX_STAT_CAP,
    TX_WRITE
  } seq_state_t;

  typedef enum logic {
    SERVED_RX = 1'b0,
    SERVED_TX = 1'b1
  } served_t;

endpackage

// File: rtl/nic_host_sequencer.sv
// Sequences the NIC processor port for one TX and one RX stream: status poll
// before every access, round-robin sharing, and capture one cycle after each read.
module nic_host_sequencer
  import nic_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             tx_valid,
  output logic             tx_ready,
  input  logic [63:0]      tx_data,
  output logic             rx_valid,
  input  logic             rx_ready,
  output logic [63:0]      rx_data,
  output logic [1:0]       nic_addr,
  output logic [63:0]      nic_d_in,
  output logic             nic_en,
  output logic             nic_wr_en,
  input  logic [63:0]      nic_d_out,
  output logic [CNT_W-1:0] tx_cnt,
  output logic [CNT_W-1:0] rx_cnt
);

  seq_state_t  state_q, state_d;
  served_t     last_served_q, last_served_d;
  logic        tx_full;
  logic [63:0] tx_hold;
  logic        rx_full;
  logic        rx_elig, tx_elig;

  assign tx_ready = !tx_full;
  assign rx_valid = rx_full;
  assign rx_elig  = !rx_full;
  assign tx_elig  = tx_full;

  always_comb begin
    state_d       = state_q;
    last_served_d = last_served_q;
    nic_en        = 1'b0;
    nic_wr_en     = 1'b0;
    nic_addr      = ADDR_IN_BUF;
    nic_d_in      = tx_hold;
    unique case (state_q)
      IDLE: begin
        // On a tie the direction not served last wins; an empty poll also counts as service.
        if (rx_elig && (!tx_elig || last_served_q == SERVED_TX)) begin
          state_d       = RX_STAT;
          last_served_d = SERVED_RX;
        end else if (tx_elig) begin
          state_d       = TX_STAT;
          last_served_d = SERVED_TX;
        end
      end
      RX_STAT: begin
        nic_en   = 1'b1;
        nic_addr = ADDR_IN_STAT;
        state_d  = RX_STAT_CAP;
      end
      RX_STAT_CAP: begin
        state_d = nic_d_out[STAT_BIT] ? RX_READ : IDLE;
      end
      RX_READ: begin
        nic_en   = 1'b1;
        nic_addr = ADDR_IN_BUF;
        state_d  = RX_READ_CAP;
      end
      RX_READ_CAP: begin
        state_d = IDLE;
      end
      TX_STAT: begin
        nic_en   = 1'b1;
        nic_addr = ADDR_OUT_STAT;
        state_d  = TX_STAT_CAP;
      end
      TX_STAT_CAP: begin
        // Nobody else fills the output buffer, so an empty status still holds at TX_WRITE.
        state_d = nic_d_out[STAT_BIT] ? IDLE : TX_WRITE;
      end
      TX_WRITE: begin
        nic_en    = 1'b1;
        nic_wr_en = 1'b1;
        nic_addr  = ADDR_OUT_BUF;
        state_d   = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      last_served_q <= SERVED_TX;
    end else begin
      state_q       <= state_d;
      last_served_q <= last_served_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tx_full <= 1'b0;
      tx_hold <= '0;
      rx_full <= 1'b0;
      rx_data <= '0;
      tx_cnt  <= '0;
      rx_cnt  <= '0;
    end else begin
      if (tx_valid && !tx_full) begin
        tx_full <= 1'b1;
        tx_hold <= tx_data;
      end else if (state_q == TX_WRITE) begin
        tx_full <= 1'b0;
        tx_cnt  <= tx_cnt + CNT_W'(1);
      end
      if (state_q == RX_READ_CAP) begin
        rx_full <= 1'b1;
        rx_data <= nic_d_out;
        rx_cnt  <= rx_cnt + CNT_W'(1);
      end else if (rx_full && rx_ready) begin
        rx_full <= 1'b0;
      end
    end
  end

endmodule
